// File: rtl/nk_iter_negator.sv
// nk_iter_negator
//   Iterative negator for an N-bit pattern, K bits per clock over N/K steps.
//   Produces z = (~x + 1) mod 2^N for both two's complement (mode=0) and
//   excess-2^(N-1) (mode=1) operands; only the overflow rule differs by mode.
//
// Ports
//   clock   in   1   all state updates on posedge
//   reset_  in   1   asynchronous active-low reset
//   soc     in   1   start of conversion, honoured only while eoc==1
//   mode    in   1   0 = two's complement, 1 = excess-2^(N-1); sampled with x
//   x       in   N   operand, sampled on the accepting edge
//   eoc     out  1   1 = idle with result valid, 0 = busy
//   z       out  N   negated pattern (registered, updated only on completion)
//   ow      out  1   overflow of the last completed operation (registered)
//
// States
//   state | meaning
//   S0    | idle, eoc=1, waiting for soc
//   S1    | busy, one K-bit digit negated per clock, N/K clocks
//   S2    | publish z/ow, raise eoc, return to S0
module nk_iter_negator #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic         mode,
  input  logic [N-1:0] x,
  output logic         eoc,
  output logic [N-1:0] z,
  output logic         ow
);

  localparam int NSTEP = N / K;
  localparam int CW    = $clog2(NSTEP) + 1;

  generate
    if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_param
      $error("nk_iter_negator: illegal N/K combination");
    end
  endgenerate

  typedef enum logic [1:0] {S0, S1, S2} star_t;

  star_t         star;
  logic [N-1:0]  xreg;
  logic          xmsb;
  logic          mode_reg;
  logic          carry;
  logic [N-1:0]  acc;
  logic [CW-1:0] count;

  // One digit of ~x + 1: invert the low K bits and add the ripple carry.
  logic [K:0]    step_sum;
  // New digit enters at the top of ACC; concatenation avoids a zero-width
  // slice when K == N.
  logic [N+K-1:0] acc_cat;

  assign step_sum = {1'b0, ~xreg[K-1:0]} + {{K{1'b0}}, carry};
  assign acc_cat  = {step_sum[K-1:0], acc};

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star     <= S0;
      xreg     <= '0;
      xmsb     <= 1'b0;
      mode_reg <= 1'b0;
      carry    <= 1'b0;
      acc      <= '0;
      count    <= '0;
      eoc      <= 1'b1;
      z        <= '0;
      ow       <= 1'b0;
    end else begin
      case (star)
        S0: begin
          if (soc) begin
            xreg     <= x;
            xmsb     <= x[N-1];
            mode_reg <= mode;
            carry    <= 1'b1;
            count    <= CW'(NSTEP);
            eoc      <= 1'b0;
            star     <= S1;
          end
        end
        S1: begin
          acc   <= acc_cat[N+K-1:K];
          xreg  <= xreg >> K;
          // Carry out of the final digit is dropped: result wraps mod 2^N.
          carry <= step_sum[K];
          count <= count - CW'(1);
          if (count == CW'(1)) star <= S2;
        end
        S2: begin
          z    <= acc;
          // c2 overflows only for 100..0; excess only for 000..0.
          ow   <= mode_reg ? (~xmsb & ~acc[N-1]) : (xmsb & acc[N-1]);
          eoc  <= 1'b1;
          star <= S0;
        end
        default: star <= S0;
      endcase
    end
  end

endmodule
